// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 encodings, default
// instruction length and the per-result flag bundle.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int BR_ILEN_BYTES = 4;

  // Address fields depend on XLEN, so the top composes them around these flags
  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } br_flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the RISC-V conditional-branch conditions.
// Drop-in replacement for the old standalone comparator.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_taken,
  output logic            o_illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_op1 == i_op2);
  assign w_lt  = ($signed(i_op1) < $signed(i_op2));
  assign w_ltu = (i_op1 < i_op2);

  // Encodings 010/011 are reserved: never taken, flagged illegal
  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = !w_eq;
      F3_BLT:  o_taken = w_lt;
      F3_BGE:  o_taken = !w_lt;
      F3_BLTU: o_taken = w_ltu;
      F3_BGEU: o_taken = !w_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: condition, target, mispredict and
// redirect PC behind an elastic valid/ready register, plus saturating stats.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int ILEN_BYTES = BR_ILEN_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_illegal,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispredicts
);

  typedef struct packed {
    br_flags_t       flags;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirectPc;
  } result_t;

  logic             r_valid;
  result_t          r_res;
  logic [CNT_W-1:0] r_cntBranches;
  logic [CNT_W-1:0] r_cntMispredicts;

  logic             w_taken;
  logic             w_illegal;
  logic             w_accept;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_fallThrough;
  result_t          w_next;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .i_funct3  (in_funct3),
    .i_op1     (in_op1),
    .i_op2     (in_op2),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  // Ready depends only on the output register so no path exists from in_valid
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  assign w_target      = in_pc + in_imm;
  assign w_fallThrough = in_pc + XLEN'(ILEN_BYTES);

  always_comb begin
    w_next                  = '0;
    w_next.flags.taken      = w_taken;
    w_next.flags.illegal    = w_illegal;
    w_next.flags.mispredict = (w_taken != in_pred_taken);
    w_next.target           = w_target;
    w_next.redirectPc       = w_taken ? w_target : w_fallThrough;
  end

  // Payload only loads on accept, which keeps it frozen under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_res   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_res   <= w_next;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_cntBranches    <= '0;
      r_cntMispredicts <= '0;
    end else if (w_accept) begin
      if (r_cntBranches != {CNT_W{1'b1}})
        r_cntBranches <= r_cntBranches + CNT_W'(1);
      if (w_next.flags.mispredict && (r_cntMispredicts != {CNT_W{1'b1}}))
        r_cntMispredicts <= r_cntMispredicts + CNT_W'(1);
    end
  end

  assign out_valid       = r_valid;
  assign out_taken       = r_res.flags.taken;
  assign out_mispredict  = r_res.flags.mispredict;
  assign out_illegal     = r_res.flags.illegal;
  assign out_target      = r_res.target;
  assign out_redirect_pc = r_res.redirectPc;
  assign cnt_branches    = r_cntBranches;
  assign cnt_mispredicts = r_cntMispredicts;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator.
- Evaluates all RV32/RV64 conditional-branch conditions in one cycle: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Computes the target, detects a mispredict against the front-end prediction and returns a redirect PC.
- Sits between the decode/execute boundary and the fetch redirect path; elastic valid/ready on both sides, flush input, saturating statistics counters.

Parameters:
- XLEN, 32, operand, PC and immediate width (32 or 64).
- CNT_W, 16, width of each statistics counter.
- ILEN_BYTES, 4, fall-through increment added to PC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream branch op valid.
- in_ready  out  1  unit can accept an op this cycle.
- in_funct3  in  3  branch funct3 encoding.
- in_op1  in  XLEN  rs1 value.
- in_op2  in  XLEN  rs2 value.
- in_pc  in  XLEN  branch PC.
- in_imm  in  XLEN  sign-extended B-immediate.
- in_pred_taken  in  1  front-end prediction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  in_pc+in_imm.
- out_mispredict  out  1  out_taken != in_pred_taken.
- out_redirect_pc  out  XLEN  correct next PC.
- out_illegal  out  1  funct3 is 010 or 011.
- flush  in  1  kill held and incoming op.
- cnt_clr  in  1  clear statistics counters.
- cnt_branches  out  CNT_W  accepted branches.
- cnt_mispredicts  out  CNT_W  accepted mispredicts.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0; out_taken, out_mispredict and out_illegal = 0; out_target and out_redirect_pc = 0; both counters = 0.
- Accept condition: in_valid && in_ready && !flush.
- in_ready = !out_valid || out_ready. Combinational from output state only; no combinational path from in_valid.
- Latency is exactly 1 cycle: an op accepted at edge N is presented with out_valid=1 after edge N.
- Hold rule: while out_valid && !out_ready, all out_* fields are stable.
- Back-to-back: an accept in the same cycle as a downstream handshake replaces the result, so out_valid stays 1.
- Output drain: handshake with no new accept sets out_valid=0.
- Condition decode by funct3:
  - 000 EQ.
  - 001 NE.
  - 100 signed LT.
  - 101 signed GE.
  - 110 unsigned LT.
  - 111 unsigned GE.
  - Signed compares use the full-width two's-complement order, including operands with differing sign bits, with no overflow error: e.g. 0x7FFFFFFF vs 0x80000000 -> BLT not taken.
- Illegal funct3 (010, 011): out_taken=0 and out_illegal=1. The op is still counted; mispredict is evaluated normally.
- Arithmetic wraps mod 2^XLEN:
  - target = pc + imm.
  - fall-through = pc + ILEN_BYTES.
- out_redirect_pc = taken ? target : fall-through, valid regardless of mispredict.
- Flush has priority over everything:
  - out_valid <= 0 and no accept this cycle.
  - Counters are not incremented for the dropped input.
  - in_ready may read 1 during flush, but the op is discarded.
- Counters:
  - cnt_branches +1 per accept.
  - cnt_mispredicts +1 per accept with mispredict.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over increment: cleared to 0 and increments that cycle are lost.
  - Reset dominates everything.
- No internal state machine beyond the output register's occupied/empty bit.

Decomposition:
- Shared package `branch_pkg`:
  - funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - ILEN_BYTES default.
  - Struct/typedef of the result bundle: taken, target, mispredict, redirect_pc, illegal.
- One sub-module: `branch_cond_eval`. Purely combinational; funct3, op1, op2 -> taken, illegal; parametrised by XLEN. It replaces the old comparator in new designs.
- Top level holds the pipeline register, handshake and counters.

Test Plan:
- BEQ: op1=op2=0x12345678, pc=0x100, imm=0x20, pred=0 -> next cycle out_valid=1, taken=1, mispredict=1, redirect=0x120, cnt_branches=1, cnt_mispredicts=1.
- Signed/unsigned: op1=0xFFFFFFFF, op2=0x00000001. BLT -> taken=1; BLTU -> taken=0; BGEU -> taken=1; BGE, pc=0x200, pred=0 -> taken=0, redirect=0x204.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, counter unchanged. Release -> in_ready=1 and back-to-back results with out_valid continuous.
- Flush: flush=1 while a result is held and in_valid=1 -> next cycle out_valid=0, counters unchanged.
- Illegal funct3 011, pred=1 -> taken=0, illegal=1, mispredict=1, both counters +1.
- CNT_W=4: 17 mispredicted branches -> both counters stick at 15. cnt_clr asserted together with an accept -> both 0. Reset asserted mid-stream -> out_valid=0 on the next edge.
